rom_bus_ctrl: RTL and testbench

- Program-memory controller on the CPU's 4-bit multiplexed bus.
- Tracks the 8-subcycle instruction cycle from `sync`, captures the 12-bit fetch address in subcycles 0-2, reads a synchronous 8-bit memory, and drives the opcode nibbles in subcycles 3-4.
- Also arbitrates a host load/readback port into the same memory. Host access uses idle bus slots only; the CPU fetch always has priority.

---
 rtl/rom_bus_ctrl_if.sv | 29 ++
 rtl/rom_bus_ctrl.sv | 128 ++++++++++++
 tb/tb_rom_bus_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rom_bus_ctrl_if.sv
// CPU multiplexed-bus and host load/readback signals of the program-memory controller.
// host_err exists only when ROM_BUS_CTRL_WRITE_PROTECT_EN is defined.
interface rom_bus_ctrl_if;
    logic        sync;
    logic [3:0]  bus_in;
    logic [3:0]  bus_out;
    logic        bus_oe;
    logic        host_req;
    logic        host_we;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        locked;
    logic        sync_err;
`ifdef ROM_BUS_CTRL_WRITE_PROTECT_EN
    logic        host_err;

    modport master (output sync, bus_in, host_req, host_we, host_addr, host_wdata,
                    input  bus_out, bus_oe, host_ack, host_rdata, locked, sync_err, host_err);
    modport slave  (input  sync, bus_in, host_req, host_we, host_addr, host_wdata,
                    output bus_out, bus_oe, host_ack, host_rdata, locked, sync_err, host_err);
`else
    modport master (output sync, bus_in, host_req, host_we, host_addr, host_wdata,
                    input  bus_out, bus_oe, host_ack, host_rdata, locked, sync_err);
    modport slave  (input  sync, bus_in, host_req, host_we, host_addr, host_wdata,
                    output bus_out, bus_oe, host_ack, host_rdata, locked, sync_err);
`endif
endinterface

// File: rtl/rom_bus_ctrl.sv
// Program-memory controller: 8-subcycle fetch on the 4-bit CPU bus plus host load/readback in idle slots.
// Latency: fetch addr in subcycle 2, opcode nibbles in 3-4; host access acks one clock after it starts.
// Backpressure: host_req is held until host_ack; CPU fetch always wins (ROM_BUS_CTRL_WRITE_PROTECT_EN adds host_err).
module rom_bus_ctrl #(
    parameter int unsigned AW     = 12,
    parameter logic [11:0] WP_TOP = 12'h0FF
) (
    input  logic          clock,
    input  logic          reset,
    rom_bus_ctrl_if.slave bus,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  addr_lo;
    logic [7:0]  opbuf;
    logic [7:0]  rdata_q;
    logic        ack_q;
    logic        rd_q;
    logic        err_q;
    logic        sync_err_q;

    logic        run;
    logic        fetch_a;
    logic        host_start;
    logic        wp_hit;
    logic [11:0] fetch_full;

`ifdef ROM_BUS_CTRL_WRITE_PROTECT_EN
    assign wp_hit       = bus.host_addr[AW-1:0] <= WP_TOP[AW-1:0];
    assign bus.host_err = err_q && run;
`else
    logic unused_wp;
    assign wp_hit    = 1'b0;
    assign unused_wp = ^{WP_TOP, err_q};
`endif

    // Reset gates the combinational outputs so an aborted access never acks.
    assign run        = !reset;
    assign fetch_a    = run && (state == LOCKED) && (cnt == 3'd2);
    assign host_start = run && bus.host_req && !ack_q &&
                        ((state == UNLOCKED) || (cnt == 3'd5));
    assign fetch_full = {bus.bus_in, addr_lo};

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (fetch_a) begin
            mem_addr = fetch_full[AW-1:0];
            mem_re   = 1'b1;
        end else if (host_start) begin
            mem_addr = bus.host_addr[AW-1:0];
            if (bus.host_we) begin
                mem_we    = !wp_hit;
                mem_wdata = bus.host_wdata;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    always_comb begin
        bus.bus_out = 4'h0;
        bus.bus_oe  = 1'b0;
        if (run && (state == LOCKED) && (cnt == 3'd3)) begin
            bus.bus_out = mem_rdata[7:4];
            bus.bus_oe  = 1'b1;
        end else if (run && (state == LOCKED) && (cnt == 3'd4)) begin
            bus.bus_out = opbuf[3:0];
            bus.bus_oe  = 1'b1;
        end
    end

    // Read data is live from memory in the ack clock, then held in rdata_q.
    assign bus.host_ack   = ack_q && run;
    assign bus.host_rdata = (rd_q && run) ? mem_rdata : rdata_q;
    assign bus.locked     = (state == LOCKED);
    assign bus.sync_err   = sync_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= UNLOCKED;
            cnt        <= 3'd0;
            addr_lo    <= 8'h00;
            opbuf      <= 8'h00;
            rdata_q    <= 8'h00;
            ack_q      <= 1'b0;
            rd_q       <= 1'b0;
            err_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            ack_q <= host_start;
            rd_q  <= host_start && !bus.host_we;
            err_q <= host_start && bus.host_we && wp_hit;
            if (rd_q) rdata_q <= mem_rdata;

            if (!bus.sync) begin
                state <= LOCKED;
                cnt   <= 3'd0;
            end else if (state == LOCKED) begin
                if (cnt == 3'd7) begin
                    state      <= UNLOCKED;
                    cnt        <= 3'd0;
                    sync_err_q <= 1'b1;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end

            if (state == LOCKED) begin
                case (cnt)
                    3'd0:    addr_lo[3:0] <= bus.bus_in;
                    3'd1:    addr_lo[7:4] <= bus.bus_in;
                    3'd3:    opbuf        <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Directed vector bench for rom_bus_ctrl with a behavioural synchronous memory.
module tb_rom_bus_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem [0:4095];

    int checks = 0;
    int errors = 0;

    rom_bus_ctrl_if bus ();

    rom_bus_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        sync;
        logic [3:0]  bin;
        logic        req;
        logic        we;
        logic [11:0] haddr;
        logic [7:0]  hwd;
        logic [3:0]  e_out;
        logic        e_oe;
        logic [11:0] e_maddr;
        logic        e_re;
        logic        e_we;
        logic [7:0]  e_wd;
        logic        e_ack;
        logic [7:0]  e_rd;
        logic        e_lock;
        logic        e_err;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(logic s, logic [3:0] b, logic r, logic w, logic [11:0] a, logic [7:0] d,
                                logic [3:0] o, logic oe, logic [11:0] ma, logic re, logic we,
                                logic [7:0] wd, logic ack, logic [7:0] rd, logic lk, logic er);
        vec_t v;
        v.sync = s;  v.bin = b;  v.req = r;  v.we = w;  v.haddr = a;  v.hwd = d;
        v.e_out = o; v.e_oe = oe; v.e_maddr = ma; v.e_re = re; v.e_we = we; v.e_wd = wd;
        v.e_ack = ack; v.e_rd = rd; v.e_lock = lk; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [3:0] b, input logic r, input logic w,
                         input logic [11:0] a, input logic [7:0] d);
        bus.sync = s; bus.bus_in = b; bus.host_req = r; bus.host_we = w;
        bus.host_addr = a; bus.host_wdata = d;
    endtask

    initial begin
        mem[12'h234] = 8'hD7;
        mem[12'h567] = 8'h3C;
        mem_rdata = 8'h00;

        //              sync bin req we addr    wdata   out  oe addr   re we wd    ack rd     lk er
        vecs[0]  = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 0, 1, 1, 12'h100, 8'h5A,  4'h0, 0, 12'h100, 0, 1, 8'h5A, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 12'h100, 8'h5A,  4'h0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h100, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[4]  = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h5A, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 0, 0);
        vecs[6]  = mk(1, 4, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[7]  = mk(1, 3, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[8]  = mk(1, 2, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h234, 1, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[9]  = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'hD, 1, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[10] = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'h7, 1, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[11] = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h100, 1, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[12] = mk(1, 0, 1, 0, 12'h100, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 1, 8'h5A, 1, 0);
        vecs[13] = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 0);
        vecs[14] = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 0, 1);
        vecs[16] = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[17] = mk(0, 0, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[18] = mk(1, 7, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[19] = mk(1, 6, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[20] = mk(1, 5, 0, 0, 12'h000, 8'h00,  4'h0, 0, 12'h567, 1, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[21] = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'h3, 1, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);
        vecs[22] = mk(1, 0, 0, 0, 12'h000, 8'h00,  4'hC, 1, 12'h000, 0, 0, 8'h00, 0, 8'h5A, 1, 1);

        reset = 1'b1;
        drive(1, 0, 0, 0, 12'h000, 8'h00);
        repeat (3) @(posedge clock);

        for (int i = 0; i < 23; i++) begin
            #1;
            reset = 1'b0;
            drive(vecs[i].sync, vecs[i].bin, vecs[i].req, vecs[i].we, vecs[i].haddr, vecs[i].hwd);
            @(negedge clock);
            chk("bus_out",    i, 32'(bus.bus_out),    32'(vecs[i].e_out));
            chk("bus_oe",     i, 32'(bus.bus_oe),     32'(vecs[i].e_oe));
            chk("mem_addr",   i, 32'(mem_addr),       32'(vecs[i].e_maddr));
            chk("mem_re",     i, 32'(mem_re),         32'(vecs[i].e_re));
            chk("mem_we",     i, 32'(mem_we),         32'(vecs[i].e_we));
            chk("mem_wdata",  i, 32'(mem_wdata),      32'(vecs[i].e_wd));
            chk("host_ack",   i, 32'(bus.host_ack),   32'(vecs[i].e_ack));
            chk("host_rdata", i, 32'(bus.host_rdata), 32'(vecs[i].e_rd));
            chk("locked",     i, 32'(bus.locked),     32'(vecs[i].e_lock));
            chk("sync_err",   i, 32'(bus.sync_err),   32'(vecs[i].e_err));
            @(posedge clock);
        end

        // Reset lands in the clock after a host read starts: the access is dropped.
        #1 reset = 1'b1;
        drive(1, 0, 0, 0, 12'h000, 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1, 0, 1, 0, 12'h234, 8'h00);
        @(negedge clock);
        chk("rst_rd_re",   100, 32'(mem_re),   32'd1);
        chk("rst_rd_addr", 100, 32'(mem_addr), 32'h234);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_ack_mid", 101, 32'(bus.host_ack), 32'd0);
        chk("rst_re_mid",  101, 32'(mem_re),       32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1, 0, 0, 0, 12'h000, 8'h00);
        @(negedge clock);
        chk("rst_ack",    102, 32'(bus.host_ack),   32'd0);
        chk("rst_rdata",  102, 32'(bus.host_rdata), 32'd0);
        chk("rst_locked", 102, 32'(bus.locked),     32'd0);
        chk("rst_serr",   102, 32'(bus.sync_err),   32'd0);
        chk("rst_oe",     102, 32'(bus.bus_oe),     32'd0);
        chk("rst_memwe",  102, 32'(mem_we),         32'd0);

        // Host write at the top of the protected range, then just above it.
        @(posedge clock);
        #1 drive(1, 0, 1, 1, 12'h0FF, 8'h11);
        @(negedge clock);
`ifdef ROM_BUS_CTRL_WRITE_PROTECT_EN
        chk("wp_low_we", 110, 32'(mem_we), 32'd0);
        chk("wp_low_err0", 110, 32'(bus.host_err), 32'd0);
`else
        chk("wp_low_we", 110, 32'(mem_we), 32'd1);
`endif
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("wp_low_ack", 111, 32'(bus.host_ack), 32'd1);
`ifdef ROM_BUS_CTRL_WRITE_PROTECT_EN
        chk("wp_low_err", 111, 32'(bus.host_err), 32'd1);
`endif
        @(posedge clock);
        #1 drive(1, 0, 1, 1, 12'h100, 8'h22);
        @(negedge clock);
        chk("wp_high_we", 112, 32'(mem_we), 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("wp_high_ack", 113, 32'(bus.host_ack), 32'd1);
`ifdef ROM_BUS_CTRL_WRITE_PROTECT_EN
        chk("wp_high_err", 113, 32'(bus.host_err), 32'd0);
`endif
        @(posedge clock);
        #1 drive(1, 0, 0, 0, 12'h000, 8'h00);
        @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
